handshake_slave_fifo: RTL and testbench

- Per-slave ingress buffer placed directly downstream of each crossbar slave port (one instance per slave).
- Accepts 8-bit beats on a valid/ready handshake from the crossbar and stores them in a small circular FIFO.
- Presents the beats in order to the slave core on a second valid/ready handshake, decoupling slave back-pressure from crossbar arbitration.

---
 rtl/handshake_slave_fifo.sv | 67 ++++++
 tb/tb_handshake_slave_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/handshake_slave_fifo.sv
// handshake_slave_fifo: valid/ready ingress FIFO for one crossbar slave port.
// Define HANDSHAKE_SLAVE_FIFO_ADDR_CHECK_EN to discard beats outside the BASE_ADDR[7:4] window.
module handshake_slave_fifo #(
    parameter int DEPTH = 4,
    parameter logic [7:0] BASE_ADDR = 8'h20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [7:0]                 data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [7:0]                 drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, store;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign ready_out = rst && !full;
    assign valid_out = !empty;
    assign data_out  = mem[rd_ptr];
    assign push      = valid_in && ready_out;
    assign pop       = valid_out && ready_in;

`ifdef HANDSHAKE_SLAVE_FIFO_ADDR_CHECK_EN
    // Misrouted beats still complete the handshake but never reach storage.
    assign store = push && (data_in[7:4] == BASE_ADDR[7:4]);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_count <= '0;
        else if (push && !store && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`else
    assign store      = push;
    assign drop_count = BASE_ADDR & 8'h00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(store) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= data_in;
    end
endmodule

// File: tb/tb_handshake_slave_fifo.sv
// tb_handshake_slave_fifo: directed and random stimulus against a queue-based reference model.
module tb_handshake_slave_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b0;
    logic       ready_out, valid_out, full, empty;
    logic [7:0] data_out, drop_count;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;
    byte unsigned q[$];
    int drops = 0;

    handshake_slave_fifo #(.DEPTH(DEPTH), .BASE_ADDR(8'h20)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in), .count(count), .full(full), .empty(empty),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [7:0] d);
`ifdef HANDSHAKE_SLAVE_FIFO_ADDR_CHECK_EN
        return d[7:4] == 4'h2;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_outputs();
        int n;
        n = q.size();
        check("count", 32'(count), n);
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("valid_out", 32'(valid_out), 32'(n != 0));
        check("ready_out", 32'(ready_out), 32'(rst && n < DEPTH));
        if (n != 0)
            check("data_out", 32'(data_out), 32'(q[0]));
        check("drop_count", 32'(drop_count), drops);
    endtask

    // One clock: drive at negedge, compare before the rising edge, then advance the model.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        int n;
        bit do_pop, do_push;
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        #1 check_outputs();
        @(posedge clk);
        n       = q.size();
        do_pop  = rst && n > 0 && r;
        do_push = rst && v && n < DEPTH;
        if (do_pop)
            void'(q.pop_front());
        if (do_push) begin
            if (in_window(d))
                q.push_back(d);
            else if (drops < 255)
                drops++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 3; i++)
            cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("three_pushed_head", 32'(data_out), 32'h21);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'h24, 1'b0);
        check("full_flag", 32'(full), 32'h1);
        cycle(1'b1, 8'h24, 1'b1);
        cycle(1'b1, 8'h24, 1'b0);
        repeat (6) cycle(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 16; i++)
            cycle(1'b1, 8'(8'h20 + i), 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'(8'h30 + i), 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst = 1'b0;
        q.delete();
        drops = 0;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 8'h2A, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("post_reset_head", 32'(data_out), 32'h2A);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        repeat (5) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h2B, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

`ifdef HANDSHAKE_SLAVE_FIFO_ADDR_CHECK_EN
        cycle(1'b1, 8'h25, 1'b0);
        cycle(1'b1, 8'h35, 1'b0);
        cycle(1'b1, 8'h2F, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("drop_one", 32'(drop_count), 32'h1);
        repeat (300) cycle(1'b1, 8'h35, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("drop_saturate", 32'(drop_count), 32'hFF);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
`endif

        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 2) != 0));
        repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
